// File: rtl/control_sequencer.sv
// LC-3b decode-stage control: single-cycle control_rom plus a sequencer that
// walks LDI/STI pointer chains and TRAP vector fetches while stalling fetch.

package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;

    typedef struct packed {
        lc3b_aluop  aluop;
        logic       load_regfile;
        logic       load_cc;
        logic       load_pc;
        logic       read_memory;
        logic       write_memory;
        logic [1:0] memory_wmask;
        logic [1:0] pc_mux_sel;
        logic [1:0] address_mux_sel;
        logic [1:0] wb_mux_sel;
        logic       dest_mux_sel;
        logic       sr2_mux_sel;
        logic       alua_mux_sel;
    } lc3b_control;

    // alu_add encodes as zero, so the all-zero word is the rom default / NOP.
    localparam lc3b_control CTRL_NOP = lc3b_control'('0);

endpackage

module control_rom
    import lc3b_types::*;
(
    input  lc3b_opcode  opcode,
    input  logic        ir4,
    input  logic        ir5,
    input  logic        ir11,
    output lc3b_control ctrl
);

    always_comb begin
        ctrl = CTRL_NOP;
        case (opcode)
            op_add, op_and: begin
                ctrl.aluop        = (opcode == op_add) ? alu_add : alu_and;
                ctrl.load_regfile = 1'b1;
                ctrl.load_cc      = 1'b1;
                ctrl.sr2_mux_sel  = ir5;
            end
            op_not: begin
                ctrl.aluop        = alu_not;
                ctrl.load_regfile = 1'b1;
                ctrl.load_cc      = 1'b1;
            end
            op_shf: begin
                ctrl.aluop        = !ir4 ? alu_sll : (ir5 ? alu_sra : alu_srl);
                ctrl.load_regfile = 1'b1;
                ctrl.load_cc      = 1'b1;
            end
            op_lea: begin
                ctrl.load_regfile = 1'b1;
                ctrl.load_cc      = 1'b1;
                ctrl.wb_mux_sel   = 2'd3;
            end
            op_ldr, op_ldb: begin
                ctrl.read_memory     = 1'b1;
                ctrl.load_regfile    = 1'b1;
                ctrl.load_cc         = 1'b1;
                ctrl.wb_mux_sel      = 2'd1;
                ctrl.address_mux_sel = 2'b11;
            end
            op_str, op_stb: begin
                ctrl.write_memory    = 1'b1;
                ctrl.memory_wmask    = (opcode == op_str) ? 2'b11 : 2'b01;
                ctrl.address_mux_sel = 2'b11;
                ctrl.alua_mux_sel    = 1'b1;
            end
            op_jmp: begin
                ctrl.load_pc    = 1'b1;
                ctrl.pc_mux_sel = 2'd1;
            end
            op_jsr: begin
                ctrl.load_pc      = 1'b1;
                ctrl.pc_mux_sel   = ir11 ? 2'd3 : 2'd1;
                ctrl.load_regfile = 1'b1;
                ctrl.dest_mux_sel = 1'b1;
                ctrl.wb_mux_sel   = 2'd2;
            end
            op_br: begin
                ctrl.pc_mux_sel = 2'd3;
            end
            default: ;
        endcase
    end

endmodule

module control_sequencer
    import lc3b_types::*;
#(
    parameter int IND_DEPTH      = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    input  logic        hold_in,
    input  lc3b_opcode  opcode,
    input  logic        ir4,
    input  logic        ir5,
    input  logic        ir11,
    input  logic        mem_resp,
    output lc3b_control ctrl_out,
    output logic        ctrl_valid,
    output logic        stall_fetch,
    output logic [2:0]  phase,
    output logic        timeout_err,
    output logic        illegal_op
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR,
        S_DATA,
        S_TVEC,
        S_TJUMP
    } state_t;

    state_t            state_q, state_d, cur_state;
    logic [2:0]        phase_q, phase_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_err_q, timeout_err_d;
    logic              is_sti_q, is_sti_d;
    logic              accept;
    logic              mem_phase;
    lc3b_control       rom_ctrl;

    control_rom u_rom (
        .opcode (opcode),
        .ir4    (ir4),
        .ir5    (ir5),
        .ir11   (ir11),
        .ctrl   (rom_ctrl)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            phase_q       <= 3'd0;
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
            is_sti_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
            is_sti_q      <= is_sti_d;
        end
    end

    // The accept cycle of a multi-phase opcode is already its first memory
    // phase, so it is folded into cur_state and shares that phase's logic.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        wd_d          = wd_q;
        timeout_err_d = timeout_err_q;
        is_sti_d      = is_sti_q;
        ctrl_out      = CTRL_NOP;
        ctrl_valid    = 1'b0;
        stall_fetch   = 1'b0;
        illegal_op    = 1'b0;
        mem_phase     = 1'b0;
        cur_state     = state_q;

        // Gating with reset_n keeps every output at its reset value while
        // reset is held, even if fetch keeps presenting an instruction.
        accept = instr_valid & ~hold_in & reset_n;

        if (state_q == S_IDLE && accept) begin
            case (opcode)
                op_ldi, op_sti: begin
                    cur_state = S_PTR;
                    is_sti_d  = (opcode == op_sti);
                end
                op_trap: cur_state = S_TVEC;
                op_rti:  illegal_op = 1'b1;
                default: begin
                    ctrl_out   = rom_ctrl;
                    ctrl_valid = 1'b1;
                end
            endcase
        end
        state_d = cur_state;

        case (cur_state)
            S_PTR: begin
                ctrl_valid               = 1'b1;
                stall_fetch              = 1'b1;
                mem_phase                = 1'b1;
                ctrl_out.read_memory     = 1'b1;
                ctrl_out.address_mux_sel = (phase_q == 3'd0) ? 2'b01 : 2'b10;
                if (mem_resp) begin
                    phase_d = phase_q + 3'd1;
                    wd_d    = '0;
                    if (phase_q == 3'(IND_DEPTH - 1))
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                ctrl_valid               = 1'b1;
                stall_fetch              = 1'b1;
                mem_phase                = 1'b1;
                ctrl_out.address_mux_sel = 2'b10;
                if (is_sti_q) begin
                    ctrl_out.write_memory = 1'b1;
                    ctrl_out.sr2_mux_sel  = 1'b1;
                    ctrl_out.alua_mux_sel = 1'b1;
                    ctrl_out.memory_wmask = 2'b11;
                end else begin
                    ctrl_out.read_memory  = 1'b1;
                    ctrl_out.wb_mux_sel   = 2'd1;
                    ctrl_out.load_regfile = mem_resp;
                    ctrl_out.load_cc      = mem_resp;
                end
                if (mem_resp) begin
                    state_d = S_IDLE;
                    phase_d = 3'd0;
                    wd_d    = '0;
                end
            end
            S_TVEC: begin
                ctrl_valid               = 1'b1;
                stall_fetch              = 1'b1;
                mem_phase                = 1'b1;
                ctrl_out.read_memory     = 1'b1;
                ctrl_out.address_mux_sel = 2'b00;
                if (mem_resp) begin
                    state_d = S_TJUMP;
                    phase_d = 3'd1;
                    wd_d    = '0;
                end
            end
            S_TJUMP: begin
                ctrl_valid            = 1'b1;
                stall_fetch           = 1'b1;
                ctrl_out.load_pc      = 1'b1;
                ctrl_out.pc_mux_sel   = 2'd2;
                ctrl_out.load_regfile = 1'b1;
                ctrl_out.dest_mux_sel = 1'b1;
                ctrl_out.wb_mux_sel   = 2'd2;
                state_d               = S_IDLE;
                phase_d               = 3'd0;
            end
            default: ;
        endcase

        // A response in the would-be timeout cycle completes the phase above
        // and never reaches this branch, so the response wins.
        if (TIMEOUT_CYCLES != 0 && mem_phase && !mem_resp) begin
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_err_d = 1'b1;
                state_d       = S_IDLE;
                phase_d       = 3'd0;
                wd_d          = '0;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    assign phase       = phase_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: a phase-level model
// expands each instruction into expected per-cycle outputs for a monitor.

module tb_control_sequencer;
    import lc3b_types::*;

    localparam int IND = 2;
    localparam int TO  = 5;

    typedef struct {
        logic        iv;
        logic        hold;
        logic        resp;
        logic        r4;
        logic        r5;
        logic        r11;
        lc3b_opcode  op;
        logic        valid;
        logic        stall;
        logic        ill;
        logic        tmo;
        logic [2:0]  ph;
        lc3b_control ctrl;
    } cyc_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        hold_in = 1'b0;
    lc3b_opcode  opcode = op_br;
    logic        ir4 = 1'b0;
    logic        ir5 = 1'b0;
    logic        ir11 = 1'b0;
    logic        mem_resp = 1'b0;
    lc3b_control ctrl_out;
    logic        ctrl_valid;
    logic        stall_fetch;
    logic [2:0]  phase;
    logic        timeout_err;
    logic        illegal_op;

    cyc_t exp_q[$];
    cyc_t mon_e;
    int   total = 0;
    int   bad = 0;
    logic sticky_tmo = 1'b0;
    bit   mon_on = 1'b0;
    bit   first_cyc = 1'b0;

    control_sequencer #(.IND_DEPTH(IND), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .hold_in     (hold_in),
        .opcode      (opcode),
        .ir4         (ir4),
        .ir5         (ir5),
        .ir11        (ir11),
        .mem_resp    (mem_resp),
        .ctrl_out    (ctrl_out),
        .ctrl_valid  (ctrl_valid),
        .stall_fetch (stall_fetch),
        .phase       (phase),
        .timeout_err (timeout_err),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    function automatic lc3b_control nop_w();
        lc3b_control c;
        c = '0;
        c.aluop = alu_add;
        return c;
    endfunction

    // Decode table of the single-cycle opcodes.
    function automatic lc3b_control rom_ref(lc3b_opcode op, logic b4, logic b5, logic b11);
        lc3b_control c = nop_w();
        if (op inside {op_add, op_and, op_not, op_shf, op_lea, op_ldr, op_ldb}) begin
            c.load_regfile = 1'b1;
            c.load_cc      = 1'b1;
        end
        case (op)
            op_add: c.sr2_mux_sel = b5;
            op_and: begin c.aluop = alu_and; c.sr2_mux_sel = b5; end
            op_not: c.aluop = alu_not;
            op_shf: c.aluop = (b4 == 1'b0) ? alu_sll : (b5 ? alu_sra : alu_srl);
            op_lea: c.wb_mux_sel = 2'd3;
            op_ldr, op_ldb: begin
                c.read_memory = 1'b1; c.wb_mux_sel = 2'd1; c.address_mux_sel = 2'b11;
            end
            op_str: begin
                c.write_memory = 1'b1; c.memory_wmask = 2'b11;
                c.address_mux_sel = 2'b11; c.alua_mux_sel = 1'b1;
            end
            op_stb: begin
                c.write_memory = 1'b1; c.memory_wmask = 2'b01;
                c.address_mux_sel = 2'b11; c.alua_mux_sel = 1'b1;
            end
            op_jmp: begin c.load_pc = 1'b1; c.pc_mux_sel = 2'd1; end
            op_jsr: begin
                c.load_pc = 1'b1; c.pc_mux_sel = b11 ? 2'd3 : 2'd1;
                c.load_regfile = 1'b1; c.dest_mux_sel = 1'b1; c.wb_mux_sel = 2'd2;
            end
            op_br: c.pc_mux_sel = 2'd3;
            default: ;
        endcase
        return c;
    endfunction

    function automatic cyc_t idle_rec();
        cyc_t r;
        r.iv = 1'b0; r.hold = 1'b0; r.resp = 1'b0;
        r.r4 = 1'b0; r.r5 = 1'b0; r.r11 = 1'b0; r.op = op_br;
        r.valid = 1'b0; r.stall = 1'b0; r.ill = 1'b0; r.ph = 3'd0;
        r.tmo = sticky_tmo; r.ctrl = nop_w();
        return r;
    endfunction

    task automatic drive(input cyc_t r);
        @(posedge clk);
        #1;
        instr_valid = r.iv;
        hold_in     = r.hold;
        opcode      = r.op;
        ir4         = r.r4;
        ir5         = r.r5;
        ir11        = r.r11;
        mem_resp    = r.resp;
        exp_q.push_back(r);
    endtask

    // One cycle of a multi-phase instruction; fetch keeps presenting it.
    task automatic seq_cycle(input cyc_t base, input lc3b_control w, input int ph, input logic resp);
        cyc_t r = base;
        r.hold  = first_cyc ? 1'b0 : 1'($urandom % 2);
        r.resp  = resp;
        r.ctrl  = w;
        r.ph    = 3'(ph);
        r.valid = 1'b1;
        r.stall = 1'b1;
        r.tmo   = sticky_tmo;
        first_cyc = 1'b0;
        drive(r);
    endtask

    // A memory phase waiting d cycles; longer than the watchdog allows aborts.
    task automatic mem_phase(input cyc_t base, input lc3b_control w_wait,
                             input lc3b_control w_resp, input int ph, input int d,
                             output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i < d && i < TO; i++)
            seq_cycle(base, w_wait, ph, 1'b0);
        if (d >= TO) begin
            aborted = 1'b1;
            sticky_tmo = 1'b1;
        end else begin
            seq_cycle(base, w_resp, ph, 1'b1);
        end
    endtask

    task automatic apply_stimulus(input lc3b_opcode op, input logic b4, input logic b5,
                                  input logic b11, input int d0, input int d1, input int d2);
        cyc_t base;
        lc3b_control w, wr;
        int d[3];
        bit ab;
        d[0] = d0; d[1] = d1; d[2] = d2;
        base = idle_rec();
        base.iv = 1'b1; base.op = op; base.r4 = b4; base.r5 = b5; base.r11 = b11;
        first_cyc = 1'b1;
        case (op)
            op_ldi, op_sti: begin
                ab = 1'b0;
                for (int k = 0; k < IND && !ab; k++) begin
                    w = nop_w();
                    w.read_memory = 1'b1;
                    w.address_mux_sel = (k == 0) ? 2'b01 : 2'b10;
                    mem_phase(base, w, w, k, d[k], ab);
                end
                if (!ab) begin
                    w = nop_w();
                    w.address_mux_sel = 2'b10;
                    if (op == op_sti) begin
                        w.write_memory = 1'b1; w.sr2_mux_sel = 1'b1;
                        w.alua_mux_sel = 1'b1; w.memory_wmask = 2'b11;
                        wr = w;
                    end else begin
                        w.read_memory = 1'b1; w.wb_mux_sel = 2'd1;
                        wr = w; wr.load_regfile = 1'b1; wr.load_cc = 1'b1;
                    end
                    mem_phase(base, w, wr, IND, d[IND], ab);
                end
            end
            op_trap: begin
                w = nop_w();
                w.read_memory = 1'b1;
                mem_phase(base, w, w, 0, d[0], ab);
                if (!ab) begin
                    w = nop_w();
                    w.load_pc = 1'b1; w.pc_mux_sel = 2'd2; w.load_regfile = 1'b1;
                    w.dest_mux_sel = 1'b1; w.wb_mux_sel = 2'd2;
                    seq_cycle(base, w, 1, 1'($urandom % 2));
                end
            end
            op_rti: begin
                base.ill = 1'b1;
                base.resp = 1'($urandom % 2);
                drive(base);
            end
            default: begin
                base.valid = 1'b1;
                base.ctrl = rom_ref(op, b4, b5, b11);
                base.resp = 1'($urandom % 2);
                drive(base);
            end
        endcase
    endtask

    // Idle cycle: nothing accepted (no instruction, or one blocked by hold_in).
    task automatic idle_cycle(input logic iv, input logic hold);
        cyc_t r = idle_rec();
        r.iv = iv;
        r.hold = hold;
        r.op = lc3b_opcode'($urandom % 16);
        r.resp = 1'($urandom % 2);
        drive(r);
    endtask

    task automatic check_output(input cyc_t e);
        total++;
        if (ctrl_valid !== e.valid || stall_fetch !== e.stall || illegal_op !== e.ill ||
            timeout_err !== e.tmo || phase !== e.ph || ctrl_out !== e.ctrl) begin
            bad++;
            $display("[TB] FAIL cycle op=%s: got v=%b s=%b i=%b t=%b ph=%0d ctrl=%h, want v=%b s=%b i=%b t=%b ph=%0d ctrl=%h",
                     e.op.name(), ctrl_valid, stall_fetch, illegal_op, timeout_err, phase, ctrl_out,
                     e.valid, e.stall, e.ill, e.tmo, e.ph, e.ctrl);
        end
    endtask

    task automatic check_reset(input string tag);
        total++;
        if (ctrl_valid !== 1'b0 || stall_fetch !== 1'b0 || illegal_op !== 1'b0 ||
            timeout_err !== 1'b0 || phase !== 3'd0 || ctrl_out !== nop_w()) begin
            bad++;
            $display("[TB] FAIL %s: got v=%b s=%b i=%b t=%b ph=%0d ctrl=%h, want all zero ctrl=%h",
                     tag, ctrl_valid, stall_fetch, illegal_op, timeout_err, phase, ctrl_out, nop_w());
        end
    endtask

    function automatic int rand_delay();
        int r = $urandom % 10;
        if (r < 8) return $urandom % 4;
        if (r == 8) return TO - 1;
        return TO;
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_output(mon_e);
            end else if (ctrl_valid || illegal_op || stall_fetch) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected output: got v=%b s=%b i=%b, want none",
                         ctrl_valid, stall_fetch, illegal_op);
            end
        end
    end

    initial begin
        lc3b_opcode op;
        #12;
        check_reset("reset_state");
        #10;
        reset_n = 1'b1;
        mon_on = 1'b1;

        apply_stimulus(op_add, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        apply_stimulus(op_ldi, 1'b0, 1'b0, 1'b0, 3, 3, 3);
        apply_stimulus(op_sti, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        apply_stimulus(op_trap, 1'b0, 1'b0, 1'b0, 1, 0, 0);
        apply_stimulus(op_rti, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        idle_cycle(1'b1, 1'b1);
        apply_stimulus(op_trap, 1'b0, 1'b0, 1'b0, TO - 1, 0, 0);
        apply_stimulus(op_ldi, 1'b0, 1'b0, 1'b0, 0, TO, 0);
        idle_cycle(1'b0, 1'b0);
        apply_stimulus(op_add, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // Reset in the middle of an LDI pointer phase.
        apply_stimulus(op_jsr, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        begin
            cyc_t base;
            lc3b_control w;
            base = idle_rec();
            base.iv = 1'b1; base.op = op_ldi;
            w = nop_w(); w.read_memory = 1'b1; w.address_mux_sel = 2'b01;
            first_cyc = 1'b1;
            seq_cycle(base, w, 0, 1'b0);
            seq_cycle(base, w, 0, 1'b0);
        end
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("reset_mid_ptr");
        mem_resp = 1'b1;
        @(posedge clk);
        #1;
        check_reset("reset_held_edge");
        instr_valid = 1'b0;
        mem_resp = 1'b0;
        #2;
        reset_n = 1'b1;
        sticky_tmo = 1'b0;
        apply_stimulus(op_ldi, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        for (int n = 0; n < 120; n++) begin
            int gap = $urandom % 3;
            for (int g = 0; g < gap; g++)
                idle_cycle(1'($urandom % 2), 1'b1);
            if ($urandom % 2)
                op = ($urandom % 3 == 0) ? op_trap : (($urandom % 2) ? op_ldi : op_sti);
            else
                op = lc3b_opcode'($urandom % 16);
            apply_stimulus(op, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
                           rand_delay(), rand_delay(), rand_delay());
        end
        idle_cycle(1'b0, 1'b0);

        for (int w = 0; w < 50 && exp_q.size() > 0; w++)
            @(posedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no completion, want finish");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
